// File: rtl/ext_bus_pkg.sv
// Shared types and default widths for ext_bus_arbiter and its grant selector.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic SPACE_RAM = 1'b0;
  localparam logic SPACE_ROM = 1'b1;

  localparam int unsigned DEF_NUM_MASTERS = 2;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_RD_LATENCY  = 1;

  // Index width that stays legal for a single master.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant selector: i_ptr names the highest-priority requester,
// search wraps upward from it; grant is one-hot (all zero when nobody requests).
module rr_arbiter
  import ext_bus_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic [IDX_W:0] w_pos;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(N)) w_pos = w_pos - (IDX_W+1)'(N);
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        o_gnt[w_pos[IDX_W-1:0]] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Multi-master arbiter for a shared data-RAM / instruction-ROM bus.
// Define EXT_BUS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_MASTERS-1:0]        i_req,
  input  logic [NUM_MASTERS-1:0]        i_we,
  input  logic [NUM_MASTERS-1:0]        i_space,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
  output logic [NUM_MASTERS-1:0]        o_gnt,
  output logic [NUM_MASTERS-1:0]        o_rvalid,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  output logic                          o_ram_we,
  output logic                          o_ram_re,
  output logic                          o_rom_re,
  input  logic [DATA_W-1:0]             i_ram_rdata,
  input  logic [DATA_W-1:0]             i_rom_rdata
);

  localparam int unsigned IDX_W     = idx_width(NUM_MASTERS);
  localparam int unsigned WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  state_t                 r_state;
  state_t                 w_next;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_we;
  logic                   r_space;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [2:0]             r_wait_cnt;
  logic [NUM_MASTERS-1:0] w_gnt;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic [IDX_W-1:0]       w_ptr;
  logic                   w_take;

  assign w_take = (r_state == ST_IDLE) && (|i_req);

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req (i_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_gnt[i]) w_gnt_idx = IDX_W'(i);
    end
  end

`ifdef EXT_BUS_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_last;

  // Reset to the last index so the first search starts at master 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_last <= IDX_W'(NUM_MASTERS - 1);
    else if (w_take) r_last <= w_gnt_idx;
  end

  assign w_ptr = (r_last == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_last + 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|i_req) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (r_we)                w_next = ST_IDLE;
        else if (RD_LATENCY > 1) w_next = ST_WAIT;
        else                     w_next = ST_RESP;
      end
      ST_WAIT:   if (r_wait_cnt == 3'(WAIT_LAST)) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_space    <= SPACE_RAM;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_take) begin
        r_idx   <= w_gnt_idx;
        r_we    <= i_we[w_gnt_idx];
        r_space <= i_space[w_gnt_idx];
        r_addr  <= i_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_wdata <= i_wdata[w_gnt_idx*DATA_W +: DATA_W];
      end
      if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                    r_wait_cnt <= '0;
    end
  end

  // Grant is gated by reset so every output reads zero while reset is held.
  always_comb begin
    o_gnt       = '0;
    o_rvalid    = '0;
    o_rdata     = '0;
    o_busy      = (r_state != ST_IDLE);
    o_err       = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_ram_we    = 1'b0;
    o_ram_re    = 1'b0;
    o_rom_re    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_rst) o_gnt = w_gnt;
      end
      ST_ACCESS: begin
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        if (r_we) begin
          if (r_space == SPACE_ROM) o_err    = 1'b1;
          else                      o_ram_we = 1'b1;
        end else begin
          if (r_space == SPACE_ROM) o_rom_re = 1'b1;
          else                      o_ram_re = 1'b1;
        end
      end
      ST_RESP: begin
        o_rvalid[r_idx] = 1'b1;
        o_rdata         = (r_space == SPACE_ROM) ? i_rom_rdata : i_ram_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level timing model.
module tb_ext_bus_arbiter;

  localparam int NM  = 2;
  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int RDL = 2;
`ifdef EXT_BUS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM-1:0]    req = '0, we = '0, space = '0;
  logic [NM*AW-1:0] addr = '0;
  logic [NM*DW-1:0] wdata = '0;
  logic [NM-1:0]    o_gnt, o_rvalid;
  logic [DW-1:0]    o_rdata, o_mem_wdata, ram_rdata, rom_rdata;
  logic             o_busy, o_err, o_ram_we, o_ram_re, o_rom_re;
  logic [AW-1:0]    o_mem_addr;

  ext_bus_arbiter #(
    .NUM_MASTERS (NM),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .RD_LATENCY  (RDL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_space     (space),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (o_gnt),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_ram_we    (o_ram_we),
    .o_ram_re    (o_ram_re),
    .o_rom_re    (o_rom_re),
    .i_ram_rdata (ram_rdata),
    .i_rom_rdata (rom_rdata)
  );

  always #5 clk = ~clk;

  // Memories with a RDL-deep read pipeline from address to data.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rom [256];
  logic [DW-1:0] ram_pipe [RDL];
  logic [DW-1:0] rom_pipe [RDL];

  always @(posedge clk) begin
    if (o_ram_we) ram[o_mem_addr] <= o_mem_wdata;
    ram_pipe[0] <= ram[o_mem_addr];
    rom_pipe[0] <= rom[o_mem_addr];
    for (int i = 1; i < RDL; i++) begin
      ram_pipe[i] <= ram_pipe[i-1];
      rom_pipe[i] <= rom_pipe[i-1];
    end
  end
  assign ram_rdata = ram_pipe[RDL-1];
  assign rom_rdata = rom_pipe[RDL-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] strb();
    return {o_rom_re, o_ram_re, o_ram_we};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({o_gnt, o_rvalid, o_busy, o_err, o_ram_we, o_ram_re, o_rom_re, o_mem_addr, o_rdata});
  endfunction

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    drive_point();
    rst = 1'b0;
  endtask

  task automatic set_m(input int k, input logic r, input logic w, input logic s,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]             = r;
    we[k]              = w;
    space[k]           = s;
    addr[k*AW +: AW]   = a;
    wdata[k*DW +: DW]  = d;
  endtask

  // Transaction-level model: a grant opens a transaction whose strobe is one
  // cycle later and whose read data arrives RDL+1 cycles after the grant.
  bit            m_active = 1'b0;
  bit            m_we, m_space;
  int            m_last = NM - 1;
  int            m_age, m_len, m_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] exp_ram [256];

  task automatic tick(output logic [NM-1:0] g);
    logic [NM-1:0] e_gnt, e_rv;
    logic          e_busy, e_err;
    logic [2:0]    e_strb;
    logic [DW-1:0] e_rdata;
    int            c;
    bit            found;
    @(negedge clk);
    e_gnt = '0; e_rv = '0; e_busy = 1'b0; e_err = 1'b0; e_strb = '0; e_rdata = '0;
    found = 1'b0; g = '0;
    if (rst) begin
      m_active = 1'b0;
      m_last   = NM - 1;
    end else begin
      if (m_active) begin
        m_age++;
        if (m_age > m_len) m_active = 1'b0;
      end
      if (!m_active) begin
        for (int i = 0; i < NM; i++) begin
          c = FIXED ? i : (m_last + 1 + i) % NM;
          if (!found && req[c]) begin
            found = 1'b1;
            m_idx = c;
          end
        end
        if (found) begin
          e_gnt[m_idx] = 1'b1;
          g        = e_gnt;
          m_active = 1'b1;
          m_age    = 0;
          m_we     = we[m_idx];
          m_space  = space[m_idx];
          m_addr   = addr[m_idx*AW +: AW];
          m_wdata  = wdata[m_idx*DW +: DW];
          m_len    = m_we ? 1 : RDL + 1;
          m_last   = m_idx;
        end
      end else begin
        e_busy = 1'b1;
        if (m_age == 1) begin
          if (!m_we)        e_strb = m_space ? 3'b100 : 3'b010;
          else if (m_space) e_err  = 1'b1;
          else begin
            e_strb          = 3'b001;
            exp_ram[m_addr] = m_wdata;
          end
        end
        if (!m_we && m_age == m_len) begin
          e_rv[m_idx] = 1'b1;
          e_rdata     = m_space ? rom[m_addr] : exp_ram[m_addr];
        end
      end
    end
    chk("rnd_gnt", 64'(o_gnt), 64'(e_gnt));
    chk("rnd_rvalid", 64'(o_rvalid), 64'(e_rv));
    chk("rnd_busy", 64'(o_busy), 64'(e_busy));
    chk("rnd_err", 64'(o_err), 64'(e_err));
    chk("rnd_strobe", 64'(strb()), 64'(e_strb));
    if (e_strb != 3'b000) chk("rnd_mem_addr", 64'(o_mem_addr), 64'(m_addr));
    if (e_strb == 3'b001) chk("rnd_mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
    if (e_rv != '0)       chk("rnd_rdata", 64'(o_rdata), 64'(e_rdata));
    drive_point();
  endtask

  typedef struct {
    logic [NM-1:0] req, we, space;
    logic [NM-1:0] gnt;
    logic [2:0]    strb;
    logic          err;
  } vec_t;

  vec_t          vecs[7];
  logic [NM-1:0] g;
  logic [NM-1:0] pend;
  logic [NM-1:0] exp_g;
  int            cnt_a, cnt_b;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = DW'(32'hC000 ^ (a * 32'h0101));

    vecs[0] = '{req: 2'b01, we: 2'b01, space: 2'b00, gnt: 2'b01, strb: 3'b001, err: 1'b0};
    vecs[1] = '{req: 2'b10, we: 2'b00, space: 2'b00, gnt: 2'b10, strb: 3'b010, err: 1'b0};
    vecs[2] = '{req: 2'b10, we: 2'b00, space: 2'b10, gnt: 2'b10, strb: 3'b100, err: 1'b0};
    vecs[3] = '{req: 2'b10, we: 2'b10, space: 2'b10, gnt: 2'b10, strb: 3'b000, err: 1'b1};
    vecs[4] = '{req: 2'b11, we: 2'b00, space: 2'b11, gnt: 2'b01, strb: 3'b100, err: 1'b0};
    vecs[5] = '{req: 2'b00, we: 2'b00, space: 2'b00, gnt: 2'b00, strb: 3'b000, err: 1'b0};
    vecs[6] = '{req: 2'b11, we: 2'b10, space: 2'b00, gnt: 2'b01, strb: 3'b010, err: 1'b0};

    drive_point();
    chk("reset_outs", all_outs(), 64'd0);
    drive_point();
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int k = 0; k < NM; k++)
        set_m(k, vecs[v].req[k], vecs[v].we[k], vecs[v].space[k], AW'(32'h20 + k), DW'(32'hA000 + k));
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", v), 64'(o_gnt), 64'(vecs[v].gnt));
      chk($sformatf("vec%0d_idle_busy", v), 64'(o_busy), 64'd0);
      drive_point();
      req = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_strobe", v), 64'(strb()), 64'(vecs[v].strb));
      chk($sformatf("vec%0d_err", v), 64'(o_err), 64'(vecs[v].err));
      chk($sformatf("vec%0d_busy", v), 64'(o_busy), 64'(|vecs[v].req));
    end

    // Write of 0xBEEF to RAM 0x05 by master 0.
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 8'h05, 16'hBEEF);
    @(negedge clk);
    chk("wr_gnt", 64'(o_gnt), 64'(2'b01));
    drive_point();
    req = '0;
    @(negedge clk);
    chk("wr_strobe", 64'(strb()), 64'(3'b001));
    chk("wr_addr", 64'(o_mem_addr), 64'h05);
    chk("wr_wdata", 64'(o_mem_wdata), 64'hBEEF);
    chk("wr_busy", 64'(o_busy), 64'd1);
    drive_point();
    @(negedge clk);
    chk("wr_done_busy", 64'(o_busy), 64'd0);
    chk("wr_done_strobe", 64'(strb()), 64'd0);
    chk("wr_ram_content", 64'(ram[5]), 64'hBEEF);

    // Preload RAM 0x10 = 0x1234, then master 1 reads it back.
    set_m(0, 1'b1, 1'b1, 1'b0, 8'h10, 16'h1234);
    drive_point();
    req = '0;
    drive_point();
    drive_point();
    set_m(1, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    @(negedge clk);
    chk("rd_gnt_t0", 64'(o_gnt), 64'(2'b10));
    drive_point();
    req = '0;
    @(negedge clk);
    chk("rd_strobe_t1", 64'(strb()), 64'(3'b010));
    chk("rd_addr_t1", 64'(o_mem_addr), 64'h10);
    drive_point();
    @(negedge clk);
    chk("rd_wait_t2", 64'({o_busy, o_rvalid, strb()}), 64'({1'b1, 2'b00, 3'b000}));
    drive_point();
    @(negedge clk);
    chk("rd_rvalid_t3", 64'(o_rvalid), 64'(2'b10));
    chk("rd_rdata_t3", 64'(o_rdata), 64'h1234);
    drive_point();
    @(negedge clk);
    chk("rd_done_t4", 64'({o_busy, o_rvalid}), 64'd0);

    // Both masters read continuously.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 8'h40, 16'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 8'h41, 16'h0);
    for (int n = 0; n < 4; n++) begin
      g = '0;
      for (int c = 0; c < 10 && g == '0; c++) begin
        @(negedge clk);
        g = o_gnt;
        if (g == '0) drive_point();
      end
      exp_g = (FIXED || (n % 2 == 0)) ? 2'b01 : 2'b10;
      chk($sformatf("rr_gnt%0d", n), 64'(g), 64'(exp_g));
      drive_point();
    end
    req = '0;

    // Write to ROM by master 1.
    do_reset();
    set_m(1, 1'b1, 1'b1, 1'b1, 8'h33, 16'h5555);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cnt_a += int'(o_err);
      cnt_b += int'(strb() != 3'b000);
      drive_point();
      req = '0;
    end
    chk("romwr_err_pulses", 64'(cnt_a), 64'd1);
    chk("romwr_strobes", 64'(cnt_b), 64'd0);

    // Reset during WAIT of a master 0 read.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 8'h30, 16'h0);
    @(negedge clk);
    chk("midrst_gnt", 64'(o_gnt), 64'(2'b01));
    drive_point();
    req = '0;
    drive_point();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", all_outs(), 64'd0);
    drive_point();
    rst = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cnt_a += int'(o_rvalid != '0) + int'(o_err);
      drive_point();
    end
    chk("midrst_no_resp", 64'(cnt_a), 64'd0);
    set_m(0, 1'b1, 1'b0, 1'b0, 8'h31, 16'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 8'h32, 16'h0);
    @(negedge clk);
    chk("midrst_next_gnt", 64'(o_gnt), 64'(2'b01));
    drive_point();
    req = '0;

    // Master 1 pulses its request only while master 0 is being served.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 8'h50, 16'h0);
    @(negedge clk);
    chk("drop_gnt0", 64'(o_gnt), 64'(2'b01));
    drive_point();
    req = '0;
    set_m(1, 1'b1, 1'b0, 1'b0, 8'h51, 16'h0);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cnt_a += int'(o_gnt[1]);
      if (c > 0) cnt_b += int'(strb() != 3'b000);
      drive_point();
      req = '0;
    end
    chk("drop_no_gnt1", 64'(cnt_a), 64'd0);
    chk("drop_no_access", 64'(cnt_b), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    drive_point();
    for (int a = 0; a < 256; a++) exp_ram[a] = ram[a];
    m_active = 1'b0;
    m_last   = NM - 1;
    pend     = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NM; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[k] = 1'b1;
            set_m(k, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom));
          end else begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[k] = 1'b0;
          req[k]  = 1'b0;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick(g);
      pend = pend & ~g;
    end
    rst = 1'b0;
    req = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_bus_arbiter.md
EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of requesting channels, range 1..8.
REQ-002 SHALL have parameter DATA_W, default 16: data bus width.
REQ-003 SHALL have parameter ADDR_W, default 8: address bus width.
REQ-004 SHALL have parameter RD_LATENCY, default 1: memory read latency in cycles from strobe to data, range 1..4.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_req, input, NUM_MASTERS: per-master access request, held until grant.
REQ-008 SHALL have port i_we, input, NUM_MASTERS: per-master write (1) or read (0).
REQ-009 SHALL have port i_space, input, NUM_MASTERS: per-master target, 0 = data RAM, 1 = instruction ROM.
REQ-010 SHALL have port i_addr, input, NUM_MASTERS*ADDR_W: packed addresses; master k occupies slice k.
REQ-011 SHALL have port i_wdata, input, NUM_MASTERS*DATA_W: packed write data.
REQ-012 SHALL have port o_gnt, output, NUM_MASTERS: one-hot, single-cycle acceptance pulse.
REQ-013 SHALL have port o_rvalid, output, NUM_MASTERS: one-hot, single-cycle read-data-valid pulse.
REQ-014 SHALL have port o_rdata, output, DATA_W: read data, valid only while any o_rvalid bit is high.
REQ-015 SHALL have port o_busy, output, 1: high whenever the FSM is not IDLE.
REQ-016 SHALL have port o_err, output, 1: single-cycle pulse on a rejected write to ROM.
REQ-017 SHALL have ports o_mem_addr (ADDR_W), o_mem_wdata (DATA_W), o_ram_we, o_ram_re, o_rom_re (1 each): memory-side outputs.
REQ-018 SHALL have ports i_ram_rdata and i_rom_rdata, input, DATA_W: memory read data.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS, WAIT and RESP.
REQ-020 IDLE: with any i_req bit set, SHALL select one master, latch its index, we, space, addr and wdata, pulse o_gnt for that master in the same cycle, and go to ACCESS.
REQ-021 ACCESS SHALL last exactly one cycle and drive o_mem_addr/o_mem_wdata from the latched values with exactly one strobe high: o_ram_we, o_ram_re or o_rom_re.
REQ-022 A write SHALL return from ACCESS to IDLE, giving 2 cycles per write.
REQ-023 A read SHALL go ACCESS -> WAIT for RD_LATENCY-1 cycles (WAIT skipped when RD_LATENCY=1) -> RESP; RESP SHALL sample the selected rdata into o_rdata, pulse the master's o_rvalid, and return to IDLE.
REQ-024 Read latency from the grant cycle to o_rvalid SHALL be RD_LATENCY+1 cycles.
REQ-025 A write with space=1 SHALL assert no strobe, SHALL pulse o_err in the ACCESS cycle, and SHALL return to IDLE.
REQ-026 Requests SHALL be ignored outside IDLE; a request dropped before its grant SHALL be discarded with no side effect.
REQ-027 Default arbitration SHALL be round-robin: search starts at last_granted+1 modulo NUM_MASTERS.
REQ-028 A sole requester SHALL be granted back-to-back without penalty.
REQ-029 All strobes, o_gnt, o_rvalid and o_err SHALL be low in every cycle not named above.

Reset
REQ-030 On i_rst: FSM SHALL go to IDLE; round-robin pointer SHALL be set so master 0 has top priority; all outputs SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction immediately, with no o_rvalid or o_err afterwards.

Configuration
REQ-032 With macro EXT_BUS_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed-priority (lowest index wins) and the round-robin pointer SHALL be removed.
REQ-033 Without EXT_BUS_ARB_FIXED_PRIO_EN, round-robin SHALL apply per REQ-027.

Structure
REQ-034 Package ext_bus_pkg SHALL hold the FSM state typedef, the SPACE_RAM/SPACE_ROM constants and the default width constants.
REQ-035 Grant selection SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out), instantiated once.

Verification
REQ-036 Read test: RD_LATENCY=2, master 1 reads RAM addr 0x10 (RAM returns 0x1234) -> o_gnt[1] at t, o_ram_re at t+1, o_rvalid[1] with o_rdata=0x1234 at t+3.
REQ-037 Write test: master 0 writes 0xBEEF to RAM 0x05 -> one-cycle o_ram_we with o_mem_addr=0x05 and o_mem_wdata=0xBEEF; o_busy high for 1 cycle.
REQ-038 Round-robin test: masters 0 and 1 both request reads continuously -> grants alternate 0,1,0,1; with EXT_BUS_ARB_FIXED_PRIO_EN defined, master 0 is always granted.
REQ-039 ROM-write test: master 1 writes with space=1 -> o_err pulses once; no strobe is asserted.
REQ-040 Mid-op reset test: i_rst asserted during WAIT -> all outputs read 0 in the same cycle, no o_rvalid follows, and the next grant after release goes to master 0.
REQ-041 Dropped-request test: i_req[1] pulsed for one cycle while busy -> no o_gnt[1] and no access for master 1.
